// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared funct3 codes, FSM state and completion status encodings for the store path
package store_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int TCNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

endpackage

// File: rtl/store_lane_enc.sv
// rtl/store_lane_enc.sv - combinational funct3/addr/wdata to byte-lane enables and replicated data
module store_lane_enc
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  dwe,
  output logic [31:0] dwdata,
  output logic        misaligned,
  output logic        illegal
);

  // Lane enables use the force-aligned offset; the misaligned flag lets the caller decide whether to trap.
  always_comb begin
    dwe        = 4'b0000;
    dwdata     = wdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_SB: begin
        dwe    = 4'b0001 << addr_lo;
        dwdata = {4{wdata[7:0]}};
      end
      F3_SH: begin
        dwe        = 4'b0011 << {addr_lo[1], 1'b0};
        dwdata     = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      F3_SW: begin
        dwe        = 4'b1111;
        dwdata     = wdata;
        misaligned = |addr_lo;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - S-type store to data-memory req/ack write port with timeout; STORE_MISALIGN_TRAP_EN traps misaligned stores
module store_unit
  import store_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [2:0]        s_funct3,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [31:0]       s_wdata,
  output logic              s_done,
  output logic [1:0]        s_err,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] daddr,
  output logic [3:0]        dwe,
  output logic [31:0]       dwdata
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   daddr_q, daddr_d;
  logic [3:0]          dwe_q, dwe_d;
  logic [31:0]         dwdata_q, dwdata_d;
  logic                s_done_q, s_done_d;
  err_e                s_err_q, s_err_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

  logic [3:0]  enc_dwe;
  logic [31:0] enc_dwdata;
  logic        enc_misaligned;
  logic        enc_illegal;
  logic        trap_misalign;
  logic        accept;

  store_lane_enc u_enc (
    .funct3     (s_funct3),
    .addr_lo    (s_addr[1:0]),
    .wdata      (s_wdata),
    .dwe        (enc_dwe),
    .dwdata     (enc_dwdata),
    .misaligned (enc_misaligned),
    .illegal    (enc_illegal)
  );

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap_misalign = enc_misaligned;
`else
  // Misaligned stores proceed force-aligned, so the flag has no consumer here.
  logic unused_misaligned;
  assign unused_misaligned = enc_misaligned;
  assign trap_misalign     = 1'b0;
`endif

  assign accept = s_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    daddr_d  = daddr_q;
    dwe_d    = dwe_q;
    dwdata_d = dwdata_q;
    s_done_d = 1'b0;
    s_err_d  = ERR_OK;
    tcnt_d   = tcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (enc_illegal) begin
            s_done_d = 1'b1;
            s_err_d  = ERR_ILLEGAL;
          end else if (trap_misalign) begin
            s_done_d = 1'b1;
            s_err_d  = ERR_MISALIGN;
          end else begin
            state_d  = ST_REQ;
            daddr_d  = {s_addr[ADDR_W-1:2], 2'b00};
            dwe_d    = enc_dwe;
            dwdata_d = enc_dwdata;
            tcnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        // An ack in the last permitted cycle still completes the store.
        if (mem_ack) begin
          state_d  = ST_IDLE;
          dwe_d    = 4'b0000;
          s_done_d = 1'b1;
          s_err_d  = ERR_OK;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d  = ST_IDLE;
          dwe_d    = 4'b0000;
          s_done_d = 1'b1;
          s_err_d  = ERR_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        dwe_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      daddr_q  <= '0;
      dwe_q    <= 4'b0000;
      dwdata_q <= 32'h0;
      s_done_q <= 1'b0;
      s_err_q  <= ERR_OK;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      daddr_q  <= daddr_d;
      dwe_q    <= dwe_d;
      dwdata_q <= dwdata_d;
      s_done_q <= s_done_d;
      s_err_q  <= s_err_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign s_ready = (state_q == ST_IDLE);
  assign mem_req = (state_q == ST_REQ);
  assign daddr   = daddr_q;
  assign dwe     = dwe_q;
  assign dwdata  = dwdata_q;
  assign s_done  = s_done_q;
  assign s_err   = s_err_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - directed self-checking bench for store_unit with TIMEOUT_CYCLES=4
module tb_store_unit;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  s_funct3;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_done;
  logic [1:0]  s_err;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] daddr;
  logic [3:0]  dwe;
  logic [31:0] dwdata;

  int n_chk;
  int n_fail;
  int cnt;

  store_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_funct3 (s_funct3),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_done   (s_done),
    .s_err    (s_err),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .daddr    (daddr),
    .dwe      (dwe),
    .dwdata   (dwdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    s_valid  = 1'b1;
    s_funct3 = f3;
    s_addr   = addr;
    s_wdata  = wd;
    @(negedge clk);
    s_valid  = 1'b0;
  endtask

  task automatic ack_done(input string tag);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, "_req_low"}, 32'(mem_req), 32'd0);
    chk({tag, "_done"}, 32'(s_done), 32'd1);
    chk({tag, "_err"}, 32'(s_err), 32'd0);
    chk({tag, "_dwe_clr"}, 32'(dwe), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] e_daddr,
                          input logic [3:0] e_dwe, input logic [31:0] e_dwdata);
    issue(f3, addr, wd);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_busy"}, 32'(s_ready), 32'd0);
    chk({tag, "_daddr"}, daddr, e_daddr);
    chk({tag, "_dwe"}, 32'(dwe), 32'(e_dwe));
    chk({tag, "_dwdata"}, dwdata, e_dwdata);
    ack_done(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(s_done), 32'd0);
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_funct3 = 3'b000;
    s_addr   = 32'h0;
    s_wdata  = 32'h0;
    mem_ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_done", 32'(s_done), 32'd0);
    chk("rst_err", 32'(s_err), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_daddr", daddr, 32'h0);
    chk("rst_dwe", 32'(dwe), 32'd0);
    chk("rst_dwdata", dwdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_store("sb", 3'b000, 32'h0010_0002, 32'hFFFF_FFF0, 32'h0010_0000, 4'b0100, 32'hF0F0_F0F0);
    do_store("sh", 3'b001, 32'h0010_0002, 32'h1234_ABCD, 32'h0010_0000, 4'b1100, 32'hABCD_ABCD);
    do_store("sw", 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0008, 4'b1111, 32'hDEAD_BEEF);

    // Ack while idle has no effect
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    chk("idle_ack_done", 32'(s_done), 32'd0);

`ifdef STORE_MISALIGN_TRAP_EN
    issue(3'b010, 32'h0000_0001, 32'h5555_AAAA);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_done", 32'(s_done), 32'd1);
    chk("mis_err", 32'(s_err), 32'd1);
    chk("mis_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    chk("mis_req2", 32'(mem_req), 32'd0);
`else
    do_store("mis", 3'b010, 32'h0000_0001, 32'h5555_AAAA, 32'h0000_0000, 4'b1111, 32'h5555_AAAA);
`endif

    issue(3'b011, 32'h0000_0010, 32'h1111_2222);
    chk("ill_req", 32'(mem_req), 32'd0);
    chk("ill_done", 32'(s_done), 32'd1);
    chk("ill_err", 32'(s_err), 32'd2);
    chk("ill_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    chk("ill_done_pulse", 32'(s_done), 32'd0);

    // Timeout: no ack, mem_req must stay up exactly 4 cycles
    issue(3'b010, 32'h0000_0020, 32'hCAFE_F00D);
    cnt = 0;
    while (mem_req && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_req_cycles", 32'(cnt), 32'd4);
    chk("tmo_done", 32'(s_done), 32'd1);
    chk("tmo_err", 32'(s_err), 32'd3);
    chk("tmo_ready", 32'(s_ready), 32'd1);
    @(negedge clk);

    // Ack in the final permitted cycle wins over timeout
    issue(3'b010, 32'h0000_0024, 32'h0BAD_CAFE);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("late_req4", 32'(mem_req), 32'd1);
    ack_done("late");
    @(negedge clk);

    // Held s_valid: inputs latched, second request taken on the done cycle
    s_valid  = 1'b1;
    s_funct3 = 3'b000;
    s_addr   = 32'h0000_0003;
    s_wdata  = 32'h0000_0011;
    @(negedge clk);
    s_addr   = 32'h0000_0005;
    s_wdata  = 32'h0000_0022;
    @(negedge clk);
    chk("hold_req", 32'(mem_req), 32'd1);
    chk("hold_dwe", 32'(dwe), 32'(4'b1000));
    chk("hold_dwdata", dwdata, 32'h1111_1111);
    chk("hold_daddr", daddr, 32'h0000_0000);
    ack_done("hold");
    @(negedge clk);
    s_valid = 1'b0;
    chk("hold2_req", 32'(mem_req), 32'd1);
    chk("hold2_dwe", 32'(dwe), 32'(4'b0010));
    chk("hold2_daddr", daddr, 32'h0000_0004);
    chk("hold2_dwdata", dwdata, 32'h2222_2222);
    ack_done("hold2");
    @(negedge clk);

    // Asynchronous reset while a request is outstanding
    issue(3'b000, 32'h0000_0040, 32'h0000_0077);
    chk("arst_pre_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_done", 32'(s_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    chk("arst_no_done", 32'(s_done), 32'd0);
    do_store("post", 3'b000, 32'h0010_0001, 32'h0000_00AB, 32'h0010_0000, 4'b0010, 32'hABAB_ABAB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store-side counterpart of the load extraction path: takes a RISC-V S-type store (SB/SH/SW) from the execute stage and drives the data-memory write port.
- Computes the word-aligned address, the byte-lane write enables and the lane-replicated write data.
- Runs a req/ack handshake to data memory with a timeout.
- Sits between the execute stage and the data-memory interface, in parallel with the load unit.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles mem_req may stay high without mem_ack before the store is aborted (range 1..255).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  store request valid.
- s_ready  out  1  unit can accept a request.
- s_funct3  in  3  instr[14:12]: 000=SB, 001=SH, 010=SW.
- s_addr  in  ADDR_W  effective byte address (rs1+imm).
- s_wdata  in  32  rs2 value.
- s_done  out  1  one-cycle pulse, store committed.
- s_err  out  2  valid with s_done: 00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout.
- mem_req  out  1  write request to data memory.
- mem_ack  in  1  memory accepted write.
- daddr  out  ADDR_W  word address {s_addr[ADDR_W-1:2],2'b00}.
- dwe  out  4  byte-lane write enables.
- dwdata  out  32  lane-replicated write data.

Behaviour:
- States IDLE, REQ. Reset → IDLE.
- Reset values: s_ready=1, s_done=0, s_err=00, mem_req=0, daddr=0, dwe=0, dwdata=0, timeout counter=0.
- s_ready=1 only in IDLE. Acceptance happens when s_valid && s_ready; all inputs are latched on acceptance.
- Write-enable and data encoding, with a = s_addr[1:0]:
  - SB: dwe=4'b0001<<a, dwdata={4{s_wdata[7:0]}}.
  - SH: dwe=4'b0011<<{a[1],1'b0}, dwdata={2{s_wdata[15:0]}}.
  - SW: dwe=4'b1111, dwdata=s_wdata.
- Misaligned means SH with a[0]=1, or SW with a!=0.
- Illegal funct3 (any value other than 000/001/010):
  - No memory access.
  - Next cycle: s_done=1, s_err=10; stay IDLE.
- Legal aligned store: IDLE→REQ.
  - mem_req=1 starting the cycle after acceptance.
  - daddr/dwe/dwdata stay stable while mem_req=1.
- In REQ, mem_ack sampled high:
  - Next cycle: mem_req=0, dwe=0, s_done=1, s_err=00, state IDLE (s_ready=1 in that same cycle).
  - Best-case latency is accept at N, mem_req at N+1, ack at N+1, done at N+2.
- Timeout counter:
  - Clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: next cycle mem_req=0, s_done=1, s_err=11, state IDLE.
  - If ack arrives in the final cycle, ack wins.
- mem_ack in IDLE is ignored.
- s_valid held high while s_ready=0 does not queue; the request is accepted on the next IDLE cycle.
- Async reset mid-REQ drops mem_req immediately. The in-flight store is discarded with no done pulse.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- When defined: a misaligned store performs no memory access and gives s_done=1, s_err=01 the next cycle.
- When undefined: low address bits are forced aligned (SH uses {a[1],1'b0}, SW uses 2'b00), the store proceeds normally, and s_err never equals 01.

Decomposition:
- Package store_pkg holds:
  - funct3 constants F3_SB, F3_SH, F3_SW.
  - enum for state.
  - enum for s_err codes (ERR_OK, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT).
- One sub-module: store_lane_enc, a combinational funct3/addr/wdata → dwe/dwdata/misaligned/illegal encoder, shared with future AMO logic.

Test Plan:
- SB: addr=0x0010_0002, wdata=0xFFFF_FFF0, ack the cycle after mem_req → daddr=0x0010_0000, dwe=0100, dwdata=0xF0F0_F0F0, s_done with s_err=00 one cycle after ack.
- SH: addr=0x0010_0002, wdata=0x1234_ABCD → dwe=1100, dwdata=0xABCD_ABCD. SW: addr=0x0000_0008, wdata=0xDEAD_BEEF → dwe=1111, dwdata=0xDEAD_BEEF.
- Misaligned SW at addr=0x0000_0001:
  - With STORE_MISALIGN_TRAP_EN: mem_req never rises, s_err=01.
  - Without it: daddr=0x0000_0000, dwe=1111, s_err=00.
- funct3=011 → no mem_req, s_done with s_err=10 next cycle, s_ready stays 1.
- Timeout with TIMEOUT_CYCLES=4 and mem_ack held 0 → mem_req high exactly 4 cycles, then s_err=11. Repeat with ack in the 4th cycle → s_err=00.
- rst_n asserted while mem_req=1 → mem_req=0 immediately, no s_done. After release, s_ready=1 and a new SB completes normally.
